// File: rtl/chip8_mem_arbiter_if.sv
// chip8_mem_arbiter_if: requester, read-return and RAM-port signals of the
// Chip-8 main RAM arbiter. The slave modport is the arbiter's view; the
// master modport is the view of the surrounding requesters plus the RAM.
interface chip8_mem_arbiter_if #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 8
);
  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_gnt;

  logic          bl_req;
  logic [AW-1:0] bl_addr;
  logic          bl_lock;
  logic          bl_gnt;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;

  logic [DW-1:0] rdata;
  logic          ld_rvalid;
  logic          bl_rvalid;
  logic          cpu_rvalid;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  modport slave (
    input  ld_req, ld_we, ld_addr, ld_wdata,
    input  bl_req, bl_addr, bl_lock,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  mem_dout,
    output ld_gnt, bl_gnt, cpu_gnt,
    output rdata, ld_rvalid, bl_rvalid, cpu_rvalid,
    output mem_en, mem_we, mem_addr, mem_din
  );

  modport master (
    output ld_req, ld_we, ld_addr, ld_wdata,
    output bl_req, bl_addr, bl_lock,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output mem_dout,
    input  ld_gnt, bl_gnt, cpu_gnt,
    input  rdata, ld_rvalid, bl_rvalid, cpu_rvalid,
    input  mem_en, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/chip8_mem_arbiter.sv
// chip8_mem_arbiter: shares the single-port Chip-8 main RAM between the ROM
// loader, the blitter sprite fetch and the CPU. One access per clock is
// granted, registered onto the RAM port, and its read data is steered back
// to the issuer by a tag pipeline that tracks the RAM read latency.
// Optional feature macro: CHIP8_ARB_RR_EN (round-robin blitter/cpu priority;
// when undefined the blitter always beats the cpu).
module chip8_mem_arbiter #(
  parameter int unsigned AW         = 12,
  parameter int unsigned DW         = 8,
  parameter int unsigned RD_LATENCY = 1
) (
  input logic                clk,
  input logic                reset,
  chip8_mem_arbiter_if.slave bus
);

  typedef enum logic { UNLOCKED = 1'b0, LOCKED = 1'b1 } lock_state_e;
  typedef enum logic [1:0] { SEL_NONE, SEL_LD, SEL_BL, SEL_CPU } sel_e;

  lock_state_e   lock_q, lock_d;
  sel_e          sel;
  logic          lock_hold;
  logic          bl_first;

  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_din_q, mem_din_d;

  // Tag per pipeline stage: one-hot {ld, bl, cpu} read marker, zero for writes.
  // Stage 0 travels with mem_*; stage RD_LATENCY lines up with mem_dout.
  logic [2:0]    tag_q [RD_LATENCY+1];
  logic [2:0]    tag_d [RD_LATENCY+1];

`ifdef CHIP8_ARB_RR_EN
  typedef enum logic { RR_BL = 1'b0, RR_CPU = 1'b1 } rr_e;
  rr_e rr_q, rr_d;

  // The pointer names the port served last; the other one wins a tie.
  always_comb begin
    bl_first = (rr_q == RR_CPU);
  end

  // Pointer follows blitter/cpu grants, frozen while the bus is locked.
  always_comb begin
    rr_d = rr_q;
    if (lock_q == UNLOCKED) begin
      if (sel == SEL_BL)       rr_d = RR_BL;
      else if (sel == SEL_CPU) rr_d = RR_CPU;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (reset) rr_q <= RR_CPU;
    else       rr_q <= rr_d;
  end
`else
  // Fixed priority: blitter always ahead of cpu.
  always_comb begin
    bl_first = 1'b1;
  end
`endif

  // Arbitration and lock next state. A lock only holds while bl_lock stays
  // high, so the cycle that drops bl_lock already arbitrates normally.
  always_comb begin
    sel       = SEL_NONE;
    lock_hold = (lock_q == LOCKED) && bus.bl_lock;
    if (reset) begin
      sel = SEL_NONE;
    end else if (lock_hold) begin
      if (bus.bl_req) sel = SEL_BL;
    end else if (bus.ld_req) begin
      sel = SEL_LD;
    end else if (bus.bl_req && bus.cpu_req) begin
      sel = bl_first ? SEL_BL : SEL_CPU;
    end else if (bus.bl_req) begin
      sel = SEL_BL;
    end else if (bus.cpu_req) begin
      sel = SEL_CPU;
    end
    lock_d = (bus.bl_lock && (lock_hold || sel == SEL_BL)) ? LOCKED : UNLOCKED;
  end

  // Transfer mux: selected access onto the RAM port, read tag into the pipe.
  always_comb begin
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    tag_d[0]   = '0;
    case (sel)
      SEL_LD: begin
        mem_en_d   = 1'b1;
        mem_we_d   = bus.ld_we;
        mem_addr_d = bus.ld_addr;
        mem_din_d  = bus.ld_wdata;
        tag_d[0]   = {~bus.ld_we, 2'b00};
      end
      SEL_BL: begin
        mem_en_d   = 1'b1;
        mem_addr_d = bus.bl_addr;
        tag_d[0]   = 3'b010;
      end
      SEL_CPU: begin
        mem_en_d   = 1'b1;
        mem_we_d   = bus.cpu_we;
        mem_addr_d = bus.cpu_addr;
        mem_din_d  = bus.cpu_wdata;
        tag_d[0]   = {2'b00, ~bus.cpu_we};
      end
      default: ;
    endcase
    for (int unsigned i = 1; i <= RD_LATENCY; i++) tag_d[i] = tag_q[i-1];
  end

  // State, RAM port and tag pipeline registers; reset drops in-flight reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q     <= UNLOCKED;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      for (int unsigned i = 0; i <= RD_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      lock_q     <= lock_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      for (int unsigned i = 0; i <= RD_LATENCY; i++) tag_q[i] <= tag_d[i];
    end
  end

  // Output drive: grants are combinational, everything else registered.
  always_comb begin
    bus.ld_gnt     = (sel == SEL_LD);
    bus.bl_gnt     = (sel == SEL_BL);
    bus.cpu_gnt    = (sel == SEL_CPU);
    bus.mem_en     = mem_en_q;
    bus.mem_we     = mem_we_q;
    bus.mem_addr   = mem_addr_q;
    bus.mem_din    = mem_din_q;
    bus.rdata      = bus.mem_dout;
    bus.ld_rvalid  = tag_q[RD_LATENCY][2];
    bus.bl_rvalid  = tag_q[RD_LATENCY][1];
    bus.cpu_rvalid = tag_q[RD_LATENCY][0];
  end

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// tb_chip8_mem_arbiter: drives the arbiter with loader/blitter/cpu traffic
// against a behavioural RAM. Read returns are checked by a scoreboard that is
// filled from a shadow memory when grants are seen.
module tb_chip8_mem_arbiter;
  localparam int unsigned AW  = 12;
  localparam int unsigned DW  = 8;
  localparam int unsigned RDL = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  chip8_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  chip8_mem_arbiter #(.AW(AW), .DW(DW), .RD_LATENCY(RDL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;

  function automatic logic [DW-1:0] init_byte(input int unsigned a);
    logic [11:0] v;
    v = a[11:0];
    if (v == 12'h200) return 8'h12;
    return v[7:0] ^ v[11:4];
  endfunction

  // Behavioural RAM behind the arbiter
  logic [DW-1:0] ram     [4096];
  logic [DW-1:0] exp_mem [4096];
  logic [DW-1:0] rd_pipe [RDL];
  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i]     <= init_byte(i);
      exp_mem[i] = init_byte(i);
    end
  end
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
    rd_pipe[0] <= ram[bus.mem_addr];
    for (int k = 1; k < RDL; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign bus.mem_dout = rd_pipe[RDL-1];

  typedef struct packed {
    logic [31:0]   due;
    logic [2:0]    vec;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sbq[$];

  function automatic logic [2:0] gnt_vec();
    return {bus.ld_gnt, bus.bl_gnt, bus.cpu_gnt};
  endfunction

  function automatic logic [2:0] rv_vec();
    return {bus.ld_rvalid, bus.bl_rvalid, bus.cpu_rvalid};
  endfunction

  // Monitor: grant sanity, scoreboard push on grant, pop/compare on return.
  logic [2:0]    m_act, m_expv, m_gv, m_rv;
  logic [DW-1:0] m_expd;
  exp_t          m_e;
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      sbq.delete();
    end else begin
      m_act  = rv_vec();
      m_expv = 3'b000;
      m_expd = '0;
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        m_expv = sbq[0].vec;
        m_expd = sbq[0].data;
        void'(sbq.pop_front());
      end
      if (m_act != 3'b000 || m_expv != 3'b000) begin
        n_checks++;
        if (m_act !== m_expv || (m_expv != 3'b000 && bus.rdata !== m_expd)) begin
          n_errors++;
          $display("FAIL rvalid_sb cyc=%0d: got vec=%b data=%h, want vec=%b data=%h",
                   cyc, m_act, bus.rdata, m_expv, m_expd);
        end
      end
      m_gv = gnt_vec();
      m_rv = {bus.ld_req, bus.bl_req, bus.cpu_req};
      if (m_rv != 3'b000) begin
        n_checks++;
        if ($countones(m_gv) > 1 || (m_gv & ~m_rv) != 3'b000) begin
          n_errors++;
          $display("FAIL gnt_sanity cyc=%0d: got gnt=%b req=%b, want onehot0 subset of req",
                   cyc, m_gv, m_rv);
        end
      end
      m_e.due = cyc + 1 + RDL;
      if (m_gv == 3'b100) begin
        if (bus.ld_we) exp_mem[bus.ld_addr] = bus.ld_wdata;
        else begin m_e.vec = 3'b100; m_e.data = exp_mem[bus.ld_addr]; sbq.push_back(m_e); end
      end else if (m_gv == 3'b010) begin
        m_e.vec = 3'b010; m_e.data = exp_mem[bus.bl_addr]; sbq.push_back(m_e);
      end else if (m_gv == 3'b001) begin
        if (bus.cpu_we) exp_mem[bus.cpu_addr] = bus.cpu_wdata;
        else begin m_e.vec = 3'b001; m_e.data = exp_mem[bus.cpu_addr]; sbq.push_back(m_e); end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.ld_req = 1'b0; bus.ld_we = 1'b0; bus.ld_addr = '0; bus.ld_wdata = '0;
    bus.bl_req = 1'b0; bus.bl_addr = '0; bus.bl_lock = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
  endtask

  task automatic test_reset;
    idle();
    reset = 1'b1;
    bus.ld_req = 1'b1; bus.bl_req = 1'b1; bus.cpu_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (gnt_vec() !== 3'b000) begin
        n_errors++; $display("FAIL reset_gnt: got %b want 000", gnt_vec());
      end
      n_checks++;
      if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_din, rv_vec()} !== '0) begin
        n_errors++;
        $display("FAIL reset_outputs: got en=%b we=%b addr=%h din=%h rv=%b want all 0",
                 bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_din, rv_vec());
      end
      step();
    end
    reset = 1'b0;
    idle();
    step();
  endtask

  task automatic test_cpu_read;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h200;
    @(negedge clk);
    n_checks++;
    if (gnt_vec() !== 3'b001) begin
      n_errors++; $display("FAIL cpu_read_gnt: got %b want 001", gnt_vec());
    end
    step();
    bus.cpu_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 12'h200}) begin
      n_errors++;
      $display("FAIL cpu_read_issue: got en=%b we=%b addr=%h want 1 0 200",
               bus.mem_en, bus.mem_we, bus.mem_addr);
    end
    repeat (RDL) begin step(); @(negedge clk); end
    n_checks++;
    if ({bus.cpu_rvalid, bus.rdata} !== {1'b1, 8'h12}) begin
      n_errors++;
      $display("FAIL cpu_read_data: got rvalid=%b rdata=%h want 1 12", bus.cpu_rvalid, bus.rdata);
    end
    step();
  endtask

  task automatic test_priority;
    bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 12'h010;
    bus.bl_req = 1'b1; bus.bl_addr = 12'h020;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h030;
    @(negedge clk);
    n_checks++;
    if (gnt_vec() !== 3'b100) begin
      n_errors++; $display("FAIL prio_ld: got %b want 100", gnt_vec());
    end
    step(); bus.ld_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (gnt_vec() !== 3'b010) begin
      n_errors++; $display("FAIL prio_bl: got %b want 010", gnt_vec());
    end
    step(); bus.bl_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (gnt_vec() !== 3'b001) begin
      n_errors++; $display("FAIL prio_cpu: got %b want 001", gnt_vec());
    end
    step(); bus.cpu_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.mem_en, bus.mem_addr} !== {1'b1, 12'h030}) begin
      n_errors++; $display("FAIL prio_issue: got en=%b addr=%h want 1 030", bus.mem_en, bus.mem_addr);
    end
    step();
  endtask

  task automatic test_lock_burst;
    bus.bl_req = 1'b1; bus.bl_lock = 1'b1; bus.bl_addr = 12'h300;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h123;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_checks++;
      if (gnt_vec() !== 3'b010) begin
        n_errors++; $display("FAIL lock_burst_%0d: got %b want 010", i, gnt_vec());
      end
      step();
      bus.bl_addr = bus.bl_addr + 12'd1;
    end
    bus.bl_req = 1'b0; bus.bl_lock = 1'b0;
    @(negedge clk);
    n_checks++;
    if (gnt_vec() !== 3'b001) begin
      n_errors++; $display("FAIL lock_release: got %b want 001", gnt_vec());
    end
    step(); bus.cpu_req = 1'b0;
    step();
  endtask

  task automatic test_lock_loader;
    logic [2:0] exp_g [6];
    exp_g[0] = 3'b010; exp_g[1] = 3'b010; exp_g[2] = 3'b000;
    exp_g[3] = 3'b100; exp_g[4] = 3'b001; exp_g[5] = 3'b100;
    bus.ld_we = 1'b0; bus.ld_addr = 12'h0A0; bus.bl_addr = 12'h0B0;
    bus.cpu_we = 1'b0; bus.cpu_addr = 12'h0C0;
    for (int i = 0; i < 6; i++) begin
      bus.bl_req  = (i < 2);
      bus.bl_lock = (i != 3);
      bus.ld_req  = (i >= 1 && i <= 3) || (i == 5);
      bus.cpu_req = (i >= 4);
      @(negedge clk);
      n_checks++;
      if (gnt_vec() !== exp_g[i]) begin
        n_errors++; $display("FAIL lock_loader_%0d: got %b want %b", i, gnt_vec(), exp_g[i]);
      end
      step();
    end
    idle();
    step();
  endtask

  task automatic test_raw;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 12'h400; bus.cpu_wdata = 8'hA5;
    @(negedge clk);
    n_checks++;
    if (gnt_vec() !== 3'b001) begin
      n_errors++; $display("FAIL raw_wr_gnt: got %b want 001", gnt_vec());
    end
    step();
    bus.cpu_we = 1'b0;
    @(negedge clk);
    n_checks++;
    if (gnt_vec() !== 3'b001) begin
      n_errors++; $display("FAIL raw_rd_gnt: got %b want 001", gnt_vec());
    end
    step();
    bus.cpu_req = 1'b0;
    repeat (RDL - 1) begin @(negedge clk); step(); end
    @(negedge clk);
    n_checks++;
    if (rv_vec() !== 3'b000) begin
      n_errors++; $display("FAIL raw_no_wr_rvalid: got %b want 000", rv_vec());
    end
    step();
    @(negedge clk);
    n_checks++;
    if ({bus.cpu_rvalid, bus.rdata} !== {1'b1, 8'hA5}) begin
      n_errors++;
      $display("FAIL raw_rd_data: got rvalid=%b rdata=%h want 1 a5", bus.cpu_rvalid, bus.rdata);
    end
    step();
  endtask

  task automatic test_rr;
    logic [2:0] want;
    reset = 1'b1; step(); reset = 1'b0;
    bus.bl_req = 1'b1; bus.bl_addr = 12'h500;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h501;
    for (int i = 0; i < 8; i++) begin
`ifdef CHIP8_ARB_RR_EN
      want = (i % 2 == 0) ? 3'b010 : 3'b001;
`else
      want = 3'b010;
`endif
      @(negedge clk);
      n_checks++;
      if (gnt_vec() !== want) begin
        n_errors++; $display("FAIL rr_%0d: got %b want %b", i, gnt_vec(), want);
      end
      step();
    end
    idle();
    step();
  endtask

  task automatic test_back_to_back;
    logic [AW-1:0] prev_addr;
    logic          prev_we;
    logic [DW-1:0] prev_din;
    bus.cpu_req = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.cpu_we    = (i < 4);
      bus.cpu_addr  = 12'h600 + 12'(i % 4);
      bus.cpu_wdata = 8'hC0 + 8'(i);
      if (i == 8) begin
        bus.cpu_req = 1'b0;
        bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 12'h602; bus.ld_wdata = 8'h3C;
      end
      @(negedge clk);
      n_checks++;
      if (gnt_vec() !== ((i == 8) ? 3'b100 : 3'b001)) begin
        n_errors++; $display("FAIL b2b_gnt_%0d: got %b", i, gnt_vec());
      end
      if (i > 0) begin
        n_checks++;
        if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {1'b1, prev_we, prev_addr} ||
            (prev_we && bus.mem_din !== prev_din)) begin
          n_errors++;
          $display("FAIL b2b_issue_%0d: got en=%b we=%b addr=%h din=%h want 1 %b %h %h",
                   i, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_din, prev_we, prev_addr, prev_din);
        end
      end
      prev_we = bus.cpu_we; prev_addr = bus.cpu_addr; prev_din = bus.cpu_wdata;
      step();
    end
    idle();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h602;
    @(negedge clk);
    step();
    idle();
    step();
  endtask

  task automatic test_reset_midop;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h210;
    @(negedge clk);
    n_checks++;
    if (gnt_vec() !== 3'b001) begin
      n_errors++; $display("FAIL midrst_gnt: got %b want 001", gnt_vec());
    end
    step();
    reset = 1'b1; bus.cpu_addr = 12'h211;
    @(negedge clk);
    n_checks++;
    if ({gnt_vec(), bus.mem_en} !== 4'b0001) begin
      n_errors++; $display("FAIL midrst_hold: got gnt=%b en=%b want 000 1", gnt_vec(), bus.mem_en);
    end
    step();
    reset = 1'b0; idle();
    @(negedge clk);
    n_checks++;
    if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_din, rv_vec()} !== '0) begin
      n_errors++;
      $display("FAIL midrst_outputs: got en=%b we=%b addr=%h din=%h rv=%b want all 0",
               bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_din, rv_vec());
    end
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      n_checks++;
      if (rv_vec() !== 3'b000) begin
        n_errors++; $display("FAIL midrst_no_rvalid_%0d: got %b want 000", i, rv_vec());
      end
    end
    step();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_priority();
    test_lock_burst();
    test_lock_loader();
    test_raw();
    test_back_to_back();
    test_rr();
    test_reset_midop();
    repeat (RDL + 2) step();
    n_checks++;
    if (sbq.size() != 0) begin
      n_errors++; $display("FAIL sb_drain: got %0d pending reads want 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
